// File: rtl/log_capture_ctrl.sv
// log_capture_ctrl: sequences sample captures into the log RAM and serves processor reads when idle
module log_capture_ctrl #(
    parameter int NB_ADDR = 15,
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_run,
    input  logic               i_read,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_wr_en,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic [NB_DATA-1:0] o_wr_data,
    output logic               o_rd_en,
    output logic [NB_ADDR-1:0] o_rd_addr,
    input  logic [NB_DATA-1:0] i_rd_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_mem_full,
    output logic               o_busy
);
    typedef enum logic [1:0] {IDLE, CAPTURE, FULL} state_t;
    localparam logic [NB_ADDR-1:0] LAST = '1;
    state_t             state, state_nxt;
    logic               run_d;
    logic               run_pulse;
    logic               capturing;
    logic               last_wr;
    logic [NB_ADDR-1:0] cnt;
    logic               rd_q;
    logic [NB_DATA-1:0] data_q;
    assign run_pulse = i_run & ~run_d;
    assign capturing = run_pulse | (state == CAPTURE);
    assign last_wr   = (state == CAPTURE) & i_valid & (cnt == LAST);
    // RAM read data is passed through on the cycle it arrives, then held
    assign o_data    = rd_q ? i_rd_data : data_q;
    // state register
    always_ff @(posedge clk) begin
        state <= i_rst ? IDLE : state_nxt;
    end
    // a run edge always (re)starts a capture; the final write ends it
    always_comb begin
        state_nxt = state;
        if (run_pulse)
            state_nxt = CAPTURE;
        else if (last_wr)
            state_nxt = FULL;
    end
    // capture write path, status flags and run edge detector
    always_ff @(posedge clk) begin
        if (i_rst) begin
            run_d      <= 1'b0;
            cnt        <= '0;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_mem_full <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            run_d <= i_run;
            if (run_pulse) begin
                cnt        <= '0;
                o_wr_en    <= 1'b0;
                o_mem_full <= 1'b0;
                o_busy     <= 1'b1;
            end else if (state == CAPTURE) begin
                o_wr_en <= i_valid;
                if (i_valid) begin
                    o_wr_addr <= cnt;
                    o_wr_data <= i_data;
                    cnt       <= last_wr ? cnt : cnt + 1'b1;
                end
                if (last_wr) begin
                    o_mem_full <= 1'b1;
                    o_busy     <= 1'b0;
                end
            end else begin
                o_wr_en <= 1'b0;
            end
        end
    end
    // processor read path, blocked while a capture is active or starting
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_rd_en   <= 1'b0;
            o_rd_addr <= '0;
            rd_q      <= 1'b0;
            data_q    <= '0;
        end else begin
            o_rd_en <= i_read & ~capturing;
            if (i_read & ~capturing)
                o_rd_addr <= i_rd_addr;
            rd_q   <= o_rd_en;
            data_q <= o_data;
        end
    end
endmodule
